pll_reset_seq: RTL and testbench

Power-up and lock-supervision controller for the iCE40 PLL that feeds `machine`.
- Runs on the 48 MHz HFOSC clock (the PLL reference), not on the PLL output.
- Drives the PLL's RESETB, watches LOCK, and releases the CPU reset only after lock has been continuously stable.
- On lock loss it resets the CPU, then restarts the PLL with bounded retries, and latches a fault if the PLL never locks.

---
 rtl/pll_seq_pkg.sv | 58 +++++
 rtl/sync_ff.sv | 25 ++
 rtl/pll_reset_seq.sv | 139 +++++++++++++
 tb/tb_pll_reset_seq.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and width helpers for the PLL power-up / lock-supervision sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } pll_state_e;

    typedef struct packed {
        logic pll_resetb;
        logic cpu_rst_n;
        logic ready;
        logic fault;
    } pll_outs_t;

    localparam int unsigned DEF_RST_CYCLES    = 16;
    localparam int unsigned DEF_LOCK_TIMEOUT  = 65536;
    localparam int unsigned DEF_STABLE_CYCLES = 1024;
    localparam int unsigned DEF_MAX_RETRIES   = 3;

    // Counter only ever holds values up to (largest count - 1).
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    // Attempt count must reach MAX_RETRIES+1 before the fault decision.
    function automatic int unsigned att_width(input int unsigned max_retries);
        return $clog2(max_retries + 2);
    endfunction

    localparam int unsigned DEF_CNT_W =
        cnt_width(DEF_RST_CYCLES, DEF_LOCK_TIMEOUT, DEF_STABLE_CYCLES);
    localparam int unsigned DEF_ATT_W = att_width(DEF_MAX_RETRIES);

    function automatic pll_outs_t outs_for(input pll_state_e s);
        pll_outs_t o;
        o = '0;
        case (s)
            PLL_RST:   o = '{pll_resetb: 1'b0, cpu_rst_n: 1'b0, ready: 1'b0, fault: 1'b0};
            WAIT_LOCK: o = '{pll_resetb: 1'b1, cpu_rst_n: 1'b0, ready: 1'b0, fault: 1'b0};
            STABLE:    o = '{pll_resetb: 1'b1, cpu_rst_n: 1'b0, ready: 1'b0, fault: 1'b0};
            RUN:       o = '{pll_resetb: 1'b1, cpu_rst_n: 1'b1, ready: 1'b1, fault: 1'b0};
            FAULT:     o = '{pll_resetb: 1'b0, cpu_rst_n: 1'b0, ready: 1'b0, fault: 1'b1};
            default:   o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// N-stage synchronizer for a single asynchronous input, cleared by async active-low reset.
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    localparam int unsigned N = (STAGES < 2) ? 2 : STAGES;

    logic [N-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else begin
            sr <= {sr[N-2:0], d};
        end
    end

    assign q = sr[N-1];

endmodule

// File: rtl/pll_reset_seq.sv
// PLL RESETB driver and lock supervisor: releases the CPU reset only after lock has
// been stable, restarts the PLL on lock loss, and latches a fault after repeated timeouts.
module pll_reset_seq
    import pll_seq_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
    parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned MAX_RETRIES   = DEF_MAX_RETRIES,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sw_reset,
    input  logic       pll_lock,
    output logic       pll_resetb,
    output logic       cpu_rst_n,
    output logic       ready,
    output logic       fault,
    output logic [1:0] retries,
    output logic [2:0] state
);

    localparam int unsigned CNT_W = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int unsigned ATT_W = att_width(MAX_RETRIES);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [ATT_W-1:0] ATT_MAX      = ATT_W'(MAX_RETRIES);

    pll_state_e       state_q;
    logic [CNT_W-1:0] cnt;
    logic [ATT_W-1:0] attempts;
    logic [ATT_W-1:0] att_inc;
    pll_outs_t        outs;
    logic             lock_s;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_lock),
        .q     (lock_s)
    );

    assign att_inc = attempts + ATT_W'(1);

    // Outputs are loaded from the next state so they switch on the same edge as state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= PLL_RST;
            cnt      <= '0;
            attempts <= '0;
            outs     <= outs_for(PLL_RST);
        end else if (sw_reset) begin
            state_q  <= PLL_RST;
            cnt      <= '0;
            attempts <= '0;
            outs     <= outs_for(PLL_RST);
        end else begin
            case (state_q)
                PLL_RST: begin
                    if (cnt == RST_LAST) begin
                        state_q <= WAIT_LOCK;
                        cnt     <= '0;
                        outs    <= outs_for(WAIT_LOCK);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    // Lock takes precedence over a timeout landing on the same cycle.
                    if (lock_s) begin
                        state_q <= STABLE;
                        cnt     <= '0;
                        outs    <= outs_for(STABLE);
                    end else if (cnt == TIMEOUT_LAST) begin
                        attempts <= att_inc;
                        cnt      <= '0;
                        if (att_inc > ATT_MAX) begin
                            state_q <= FAULT;
                            outs    <= outs_for(FAULT);
                        end else begin
                            state_q <= PLL_RST;
                            outs    <= outs_for(PLL_RST);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        state_q <= WAIT_LOCK;
                        cnt     <= '0;
                        outs    <= outs_for(WAIT_LOCK);
                    end else if (cnt == STABLE_LAST) begin
                        state_q <= RUN;
                        cnt     <= '0;
                        outs    <= outs_for(RUN);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state_q <= PLL_RST;
                        cnt     <= '0;
                        outs    <= outs_for(PLL_RST);
                    end
                end
                FAULT: begin
                    state_q <= FAULT;
                end
                default: begin
                    state_q <= PLL_RST;
                    cnt     <= '0;
                    outs    <= outs_for(PLL_RST);
                end
            endcase
        end
    end

    assign pll_resetb = outs.pll_resetb;
    assign cpu_rst_n  = outs.cpu_rst_n;
    assign ready      = outs.ready;
    assign fault      = outs.fault;
    assign state      = state_q;

    if (ATT_W == 1) begin : g_ret_w1
        assign retries = {1'b0, attempts};
    end else if (ATT_W == 2) begin : g_ret_w2
        assign retries = attempts;
    end else begin : g_ret_sat
        assign retries = (attempts > ATT_W'(3)) ? 2'd3 : attempts[1:0];
    end

endmodule

// File: tb/tb_pll_reset_seq.sv
// Bench for pll_reset_seq: directed timing scenarios plus random lock traffic,
// every cycle compared against a timestamp-based reference model.
module tb_pll_reset_seq;

    localparam int RST_C = 4;
    localparam int TMO   = 32;
    localparam int STB   = 8;
    localparam int MAXR  = 2;
    localparam int SYNC  = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sw_reset = 1'b0;
    logic       pll_lock = 1'b0;
    logic       pll_resetb;
    logic       cpu_rst_n;
    logic       ready;
    logic       fault;
    logic [1:0] retries;
    logic [2:0] state;
    logic [8:0] dut_outs;

    always #5 clk = ~clk;

    pll_reset_seq #(
        .RST_CYCLES    (RST_C),
        .LOCK_TIMEOUT  (TMO),
        .STABLE_CYCLES (STB),
        .MAX_RETRIES   (MAXR),
        .SYNC_STAGES   (SYNC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw_reset   (sw_reset),
        .pll_lock   (pll_lock),
        .pll_resetb (pll_resetb),
        .cpu_rst_n  (cpu_rst_n),
        .ready      (ready),
        .fault      (fault),
        .retries    (retries),
        .state      (state)
    );

    assign dut_outs = {state, pll_resetb, cpu_rst_n, ready, fault, retries};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Reference model: phase plus the edge index at which it was entered.
    int m_phase;
    int m_cyc = 0;
    int m_entry;
    int m_att;
    bit lq[$];

    function automatic void model_reset();
        m_phase = 0;
        m_entry = m_cyc;
        m_att   = 0;
        lq.delete();
        for (int i = 0; i < SYNC; i++) lq.push_back(1'b0);
    endfunction

    function automatic void model_go(input int p);
        m_phase = p;
        m_entry = m_cyc;
    endfunction

    function automatic void model_step(input logic lock_in, input logic sw);
        bit seen;
        int el;
        m_cyc++;
        seen = lq.pop_front();
        lq.push_back(lock_in);
        el = m_cyc - m_entry;
        if (sw) begin
            m_att = 0;
            model_go(0);
        end else begin
            case (m_phase)
                0: if (el == RST_C) model_go(1);
                1: begin
                    if (seen) model_go(2);
                    else if (el == TMO) begin
                        m_att++;
                        model_go((m_att > MAXR) ? 4 : 0);
                    end
                end
                2: begin
                    if (!seen) model_go(1);
                    else if (el == STB) model_go(3);
                end
                3: if (!seen) model_go(0);
                default: ;
            endcase
        end
    endfunction

    function automatic logic [8:0] model_outs();
        logic [8:0] r;
        int ph;
        ph = m_phase;
        r[8:6] = ph[2:0];
        r[5]   = (m_phase >= 1 && m_phase <= 3);
        r[4]   = (m_phase == 3);
        r[3]   = (m_phase == 3);
        r[2]   = (m_phase == 4);
        r[1:0] = (m_att > 3) ? 2'd3 : 2'(m_att);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step(pll_lock, sw_reset);
        @(negedge clk);
        check("outs", {23'd0, dut_outs}, {23'd0, model_outs()});
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return pll_resetb;
            1:       return cpu_rst_n;
            2:       return (state == 3'd3);
            default: return fault;
        endcase
    endfunction

    task automatic run_until(input int sel, input logic val, input int budget, output int n);
        n = 0;
        while (sig(sel) !== val && n < budget) begin
            tick();
            n++;
        end
    endtask

    // Called from the negedge; asserts rst_n between clock edges.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        check("async_pll_resetb", {31'd0, pll_resetb}, 32'd0);
        check("async_outs", {23'd0, dut_outs}, 32'd0);
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int len;
        model_reset();
        repeat (3) tick();
        check("reset_outs", {23'd0, dut_outs}, 32'd0);

        // Clean power-up
        rst_n = 1'b1;
        run_until(0, 1'b1, 50, n);
        check("rst_to_resetb", n, RST_C);
        repeat (10) tick();
        pll_lock = 1'b1;
        run_until(1, 1'b1, 100, n);
        check("lock_to_cpu", n, SYNC + STB + 1);
        check("run_ready", {31'd0, ready}, 32'd1);
        check("run_retries", {30'd0, retries}, 32'd0);
        check("run_state", {29'd0, state}, 32'd3);

        // Lock loss in RUN
        pll_lock = 1'b0;
        run_until(1, 1'b0, 50, n);
        check("loss_to_cpu", n, SYNC + 1);
        check("loss_state", {29'd0, state}, 32'd0);
        run_until(0, 1'b1, 50, n);
        check("loss_resetb_low", n, RST_C);

        // Lock glitch during STABLE
        repeat (3) tick();
        pll_lock = 1'b1;
        repeat (5) tick();
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        run_until(1, 1'b1, 100, n);
        check("glitch_to_cpu", n, SYNC + STB + 1);
        check("glitch_retries", {30'd0, retries}, 32'd0);

        // Async reset mid-RUN
        async_reset();
        pll_lock = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;

        // Timeouts into FAULT
        for (int i = 1; i <= 3 * (RST_C + TMO); i++) begin
            tick();
            if (i == RST_C + TMO - 1) check("retry_before_1", {30'd0, retries}, 32'd0);
            if (i == RST_C + TMO)     check("retry_1", {30'd0, retries}, 32'd1);
            if (i == 2 * (RST_C + TMO)) check("retry_2", {30'd0, retries}, 32'd2);
            if (i == 3 * (RST_C + TMO) - 1) check("fault_early", {31'd0, fault}, 32'd0);
        end
        check("fault_set", {31'd0, fault}, 32'd1);
        check("fault_state", {29'd0, state}, 32'd4);
        check("fault_resetb", {31'd0, pll_resetb}, 32'd0);
        pll_lock = 1'b1;
        repeat (20) tick();
        check("fault_hold", {29'd0, state}, 32'd4);

        // sw_reset out of FAULT
        sw_reset = 1'b1;
        tick();
        sw_reset = 1'b0;
        check("sw_state", {29'd0, state}, 32'd0);
        check("sw_fault", {31'd0, fault}, 32'd0);
        check("sw_retries", {30'd0, retries}, 32'd0);

        // sw_reset in STABLE at cnt=5
        pll_lock = 1'b0;
        run_until(0, 1'b1, 50, n);
        pll_lock = 1'b1;
        repeat (SYNC + 1 + 5) tick();
        check("pre_sw_state", {29'd0, state}, 32'd2);
        sw_reset = 1'b1;
        tick();
        sw_reset = 1'b0;
        check("sw_stable_state", {29'd0, state}, 32'd0);
        run_until(2, 1'b1, 100, n);
        check("sw_stable_to_run", n, RST_C + 1 + STB);

        // Random lock traffic with occasional sw_reset and async reset
        for (int seg = 0; seg < 80; seg++) begin
            pll_lock = ($urandom_range(0, 3) != 0);
            len = $urandom_range(1, 45);
            if ($urandom_range(0, 19) == 0) begin
                async_reset();
                tick();
                rst_n = 1'b1;
            end
            for (int k = 0; k < len; k++) begin
                sw_reset = ($urandom_range(0, 63) == 0);
                tick();
            end
            sw_reset = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
